// File: rtl/nco_dither_sched.sv
// Dither source shared by NUM_CH NCO channels: one LFSR, round-robin grant
// arbitration, seed loading and an all-zero lockup guard.
module nco_dither_sched #(
    parameter int          NUM_CH    = 4,
    parameter int          OUT_SIZE  = 5,
    parameter int unsigned LSFR_POLY = 'b1110100000000000001,
    localparam int         LSFR_SIZE = $clog2(LSFR_POLY),
    localparam int         CH_W      = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req,
    input  logic                 dither_en,
    input  logic                 seed_load,
    input  logic [LSFR_SIZE-1:0] seed,
    output logic [NUM_CH-1:0]    gnt,
    output logic                 dither_valid,
    output logic [OUT_SIZE-1:0]  dither_out,
    output logic [CH_W-1:0]      dither_ch,
    output logic                 lockup
);

    localparam logic [LSFR_SIZE-1:0] POLY_MASK = LSFR_POLY[LSFR_SIZE-1:0];
    localparam logic [LSFR_SIZE-1:0] LFSR_ONE  = LSFR_SIZE'(1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_SEED} state_t;

    state_t                r_state;
    logic [LSFR_SIZE-1:0]  r_lfsr;
    logic [LSFR_SIZE-1:0]  r_seed;
    logic [CH_W-1:0]       r_ptr;
    logic [NUM_CH-1:0]     r_gnt;
    logic                  r_valid;
    logic [OUT_SIZE-1:0]   r_out;
    logic [CH_W-1:0]       r_ch;
    logic                  r_lockup;

    logic                  w_any;
    logic [CH_W-1:0]       w_idx;
    logic [CH_W-1:0]       w_ptr_nxt;
    logic [NUM_CH-1:0]     w_onehot;
    logic [LSFR_SIZE-1:0]  w_lfsr_nxt;

    // Walk offsets high-to-low so the requester closest to the pointer wins.
    always_comb begin
        int j;
        w_any = 1'b0;
        w_idx = '0;
        j     = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (req[j]) begin
                w_any = 1'b1;
                w_idx = j[CH_W-1:0];
            end
        end
    end

    assign w_ptr_nxt  = (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + CH_W'(1);
    assign w_onehot   = NUM_CH'(1) << w_idx;
    assign w_lfsr_nxt = {r_lfsr[LSFR_SIZE-2:0], ^(r_lfsr & POLY_MASK)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_INIT;
            r_lfsr   <= LFSR_ONE;
            r_seed   <= '0;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_valid  <= 1'b0;
            r_out    <= '0;
            r_ch     <= '0;
            r_lockup <= 1'b0;
        end else begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
            case (r_state)
                ST_INIT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (seed_load) begin
                        r_state <= ST_SEED;
                        r_seed  <= seed;
                    end else if (r_lfsr == '0) begin
                        r_lfsr   <= LFSR_ONE;
                        r_lockup <= 1'b1;
                    end else if (dither_en && w_any) begin
                        r_gnt   <= w_onehot;
                        r_valid <= 1'b1;
                        r_ch    <= w_idx;
                        r_out   <= r_lfsr[LSFR_SIZE-1:LSFR_SIZE-OUT_SIZE];
                        r_lfsr  <= w_lfsr_nxt;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                ST_SEED: begin
                    r_state <= ST_RUN;
                    // A zero seed would freeze the LFSR; restart from 1 and flag it.
                    if (r_seed == '0) begin
                        r_lfsr   <= LFSR_ONE;
                        r_lockup <= 1'b1;
                    end else begin
                        r_lfsr <= r_seed;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign dither_valid = r_valid;
    assign dither_out   = r_out;
    assign dither_ch    = r_ch;
    assign lockup       = r_lockup;

endmodule

// File: tb/tb_nco_dither_sched.sv
// Directed bench for nco_dither_sched: reset, round-robin grants, seeding,
// lockup, enable gating and asynchronous reset.
module tb_nco_dither_sched;

    localparam logic [18:0] POLY = 19'b1110100000000000001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic        dither_en = 1'b0;
    logic        seed_load = 1'b0;
    logic [18:0] seed = '0;
    logic [3:0]  gnt;
    logic        dither_valid;
    logic [4:0]  dither_out;
    logic [1:0]  dither_ch;
    logic        lockup;

    int total = 0;
    int bad   = 0;

    logic [18:0] m_lfsr = 19'd1;
    int          m_ptr  = 0;

    nco_dither_sched dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .dither_en   (dither_en),
        .seed_load   (seed_load),
        .seed        (seed),
        .gnt         (gnt),
        .dither_valid(dither_valid),
        .dither_out  (dither_out),
        .dither_ch   (dither_ch),
        .lockup      (lockup)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] lstep(input logic [18:0] s);
        return {s[17:0], ^(s & POLY)};
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    // Reference model of one grant: expected outputs, then advance LFSR and pointer.
    task automatic model_grant(output logic [3:0] eg, output logic [1:0] ec, output logic [4:0] eo);
        int c;
        c      = rr_pick(req, m_ptr);
        eg     = '0;
        eg[c]  = 1'b1;
        ec     = c[1:0];
        eo     = m_lfsr[18:14];
        m_lfsr = lstep(m_lfsr);
        m_ptr  = (c + 1) % 4;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        total++;
        if ({gnt, dither_valid, dither_out, dither_ch, lockup} !== 13'd0) begin
            bad++;
            $display("FAIL reset_state got gnt=%b v=%b out=%b ch=%0d lk=%b want all zero",
                     gnt, dither_valid, dither_out, dither_ch, lockup);
        end
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0000 || dither_valid !== 1'b0) begin
            bad++;
            $display("FAIL init_no_grant got gnt=%b v=%b want 0000/0", gnt, dither_valid);
        end
        m_lfsr = 19'd1;
        m_ptr  = 0;
    endtask

    task automatic test_single;
        logic [3:0] eg; logic [1:0] ec; logic [4:0] eo;
        dither_en = 1'b1;
        req       = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            model_grant(eg, ec, eo);
            total++;
            if ({gnt, dither_valid, dither_ch, dither_out} !== {eg, 1'b1, ec, eo}) begin
                bad++;
                $display("FAIL single_grant[%0d] got gnt=%b v=%b ch=%0d out=%b want gnt=%b v=1 ch=%0d out=%b",
                         i, gnt, dither_valid, dither_ch, dither_out, eg, ec, eo);
            end
        end
        total++;
        if (m_lfsr !== 19'h3f) begin
            bad++;
            $display("FAIL lfsr_seq got model=%h want 3f", m_lfsr);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] eg; logic [1:0] ec; logic [4:0] eo;
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            model_grant(eg, ec, eo);
            total++;
            if ({gnt, dither_valid, dither_ch, dither_out} !== {eg, 1'b1, ec, eo}) begin
                bad++;
                $display("FAIL rr_grant[%0d] got gnt=%b v=%b ch=%0d out=%b want gnt=%b v=1 ch=%0d out=%b",
                         i, gnt, dither_valid, dither_ch, dither_out, eg, ec, eo);
            end
        end
    endtask

    task automatic test_seed;
        logic [3:0] eg; logic [1:0] ec; logic [4:0] eo;
        req       = 4'b0101;
        seed      = 19'h40000;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        total++;
        if (gnt !== 4'b0000 || dither_valid !== 1'b0) begin
            bad++;
            $display("FAIL seed_cycle0 got gnt=%b v=%b want 0000/0", gnt, dither_valid);
        end
        tick();
        total++;
        if (gnt !== 4'b0000 || dither_valid !== 1'b0) begin
            bad++;
            $display("FAIL seed_cycle1 got gnt=%b v=%b want 0000/0", gnt, dither_valid);
        end
        m_lfsr = 19'h40000;
        tick();
        model_grant(eg, ec, eo);
        total++;
        if ({gnt, dither_valid, dither_ch, dither_out} !== {eg, 1'b1, ec, 5'b10000}) begin
            bad++;
            $display("FAIL seed_grant got gnt=%b v=%b ch=%0d out=%b want gnt=%b v=1 ch=%0d out=10000",
                     gnt, dither_valid, dither_ch, dither_out, eg, ec);
        end
    endtask

    task automatic test_seed_zero;
        logic [3:0] eg; logic [1:0] ec; logic [4:0] eo;
        seed      = 19'h0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        total++;
        if (gnt !== 4'b0000 || lockup !== 1'b0) begin
            bad++;
            $display("FAIL zseed_cycle0 got gnt=%b lk=%b want 0000/0", gnt, lockup);
        end
        tick();
        total++;
        if (gnt !== 4'b0000 || lockup !== 1'b1) begin
            bad++;
            $display("FAIL zseed_lockup got gnt=%b lk=%b want 0000/1", gnt, lockup);
        end
        m_lfsr = 19'd1;
        tick();
        model_grant(eg, ec, eo);
        total++;
        if ({gnt, dither_valid, dither_ch, dither_out, lockup} !== {eg, 1'b1, ec, 5'b00000, 1'b1}) begin
            bad++;
            $display("FAIL zseed_grant got gnt=%b v=%b ch=%0d out=%b lk=%b want gnt=%b v=1 ch=%0d out=00000 lk=1",
                     gnt, dither_valid, dither_ch, dither_out, lockup, eg, ec);
        end
    endtask

    task automatic test_enable_gate;
        logic [3:0] eg; logic [1:0] ec; logic [4:0] eo;
        logic [1:0] last_ch; logic [4:0] last_out;
        req = 4'b1111;
        tick();
        model_grant(eg, ec, eo);
        total++;
        if ({gnt, dither_valid, dither_ch, dither_out} !== {eg, 1'b1, ec, eo}) begin
            bad++;
            $display("FAIL en_pre got gnt=%b ch=%0d out=%b want gnt=%b ch=%0d out=%b",
                     gnt, dither_ch, dither_out, eg, ec, eo);
        end
        last_ch   = ec;
        last_out  = eo;
        dither_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({gnt, dither_valid, dither_ch, dither_out} !== {4'b0000, 1'b0, last_ch, last_out}) begin
                bad++;
                $display("FAIL en_off[%0d] got gnt=%b v=%b ch=%0d out=%b want gnt=0000 v=0 ch=%0d out=%b",
                         i, gnt, dither_valid, dither_ch, dither_out, last_ch, last_out);
            end
        end
        dither_en = 1'b1;
        tick();
        model_grant(eg, ec, eo);
        total++;
        if ({gnt, dither_valid, dither_ch, dither_out} !== {eg, 1'b1, last_ch + 2'd1, eo}) begin
            bad++;
            $display("FAIL en_resume got gnt=%b v=%b ch=%0d out=%b want gnt=%b v=1 ch=%0d out=%b",
                     gnt, dither_valid, dither_ch, dither_out, eg, last_ch + 2'd1, eo);
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] eg; logic [1:0] ec; logic [4:0] eo;
        req = 4'b1111;
        tick();
        model_grant(eg, ec, eo);
        #3;
        rst = 1'b0;
        #1;
        total++;
        if ({gnt, dither_valid, lockup, dither_out, dither_ch} !== 13'd0) begin
            bad++;
            $display("FAIL async_rst got gnt=%b v=%b lk=%b out=%b ch=%0d want all zero",
                     gnt, dither_valid, lockup, dither_out, dither_ch);
        end
        #2;
        rst = 1'b1;
        m_lfsr = 19'd1;
        m_ptr  = 0;
        tick();
        total++;
        if (gnt !== 4'b0000 || dither_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_init_cycle got gnt=%b v=%b want 0000/0", gnt, dither_valid);
        end
        tick();
        model_grant(eg, ec, eo);
        total++;
        if ({gnt, dither_valid, dither_ch, dither_out} !== {4'b0001, 1'b1, 2'd0, 5'b00000}) begin
            bad++;
            $display("FAIL rst_first_grant got gnt=%b v=%b ch=%0d out=%b want gnt=0001 v=1 ch=0 out=00000",
                     gnt, dither_valid, dither_ch, dither_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_seed();
        test_seed_zero();
        test_enable_gate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
